// File: rtl/mem_access_ctrl.sv
// M-stage data memory access controller for a MIPS-style pipeline.
// Drives an SRAM-like request channel, formats loads, flags misalignment.
module mem_access_ctrl #(
  parameter int ADDR_W  = 32,
  parameter bit LWLR_EN = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid,
  input  logic              flush,
  input  logic [5:0]        op,
  input  logic [ADDR_W-1:0] pc,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       rt,
  output logic              data_req,
  output logic              data_wr,
  output logic [1:0]        data_size,
  output logic [ADDR_W-1:0] data_addr,
  output logic [31:0]       data_wdata,
  output logic [3:0]        data_wstrb,
  input  logic              data_addr_ok,
  input  logic              data_data_ok,
  input  logic [31:0]       data_rdata,
  output logic              stall,
  output logic              done,
  output logic [31:0]       rdata_out,
  output logic              adesM,
  output logic              adelM,
  output logic [ADDR_W-1:0] bad_addr
);

  typedef enum logic [2:0] {
    S_IDLE, S_REQ, S_WAIT, S_DONE, S_DRAIN
  } state_t;

  localparam logic [5:0] OP_LB  = 6'b100000;
  localparam logic [5:0] OP_LH  = 6'b100001;
  localparam logic [5:0] OP_LWL = 6'b100010;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_LBU = 6'b100100;
  localparam logic [5:0] OP_LHU = 6'b100101;
  localparam logic [5:0] OP_LWR = 6'b100110;
  localparam logic [5:0] OP_SB  = 6'b101000;
  localparam logic [5:0] OP_SH  = 6'b101001;
  localparam logic [5:0] OP_SWL = 6'b101010;
  localparam logic [5:0] OP_SW  = 6'b101011;
  localparam logic [5:0] OP_SWR = 6'b101110;

  state_t            state_q, state_d;
  logic              wr_q, wr_d;
  logic [1:0]        size_q, size_d;
  logic [ADDR_W-1:0] daddr_q, daddr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [3:0]        wstrb_q, wstrb_d;
  logic [5:0]        op_q, op_d;
  logic [1:0]        off_q, off_d;
  logic [31:0]       rt_q, rt_d;
  logic [31:0]       rdata_q, rdata_d;

  logic        acc_c, st_c, lr_c, unal_c, accept;
  logic [1:0]  a_c, size_c;
  logic [3:0]  strb_c;
  logic [31:0] wdata_c, fmt_c, msh_c, mhf_c;
  logic [4:0]  sh_c, ish_c, rsh_c;

  assign a_c   = addr[1:0];
  assign sh_c  = {a_c, 3'b000};
  assign ish_c = {~a_c, 3'b000};

  // Decode the incoming op into request fields and alignment fault
  always_comb begin
    acc_c   = 1'b0;
    st_c    = 1'b0;
    lr_c    = 1'b0;
    unal_c  = 1'b0;
    size_c  = 2'd0;
    strb_c  = 4'b0000;
    wdata_c = 32'h0;
    unique case (op)
      OP_LB, OP_LBU: acc_c = 1'b1;
      OP_LH, OP_LHU: begin
        acc_c  = 1'b1;
        size_c = 2'd1;
        unal_c = a_c[0];
      end
      OP_LW: begin
        acc_c  = 1'b1;
        size_c = 2'd2;
        unal_c = |a_c;
      end
      OP_LWL, OP_LWR: begin
        acc_c  = LWLR_EN;
        lr_c   = 1'b1;
        size_c = 2'd2;
      end
      OP_SB: begin
        acc_c   = 1'b1;
        st_c    = 1'b1;
        strb_c  = 4'b0001 << a_c;
        wdata_c = {4{rt[7:0]}};
      end
      OP_SH: begin
        acc_c   = 1'b1;
        st_c    = 1'b1;
        size_c  = 2'd1;
        unal_c  = a_c[0];
        strb_c  = a_c[1] ? 4'b1100 : 4'b0011;
        wdata_c = {2{rt[15:0]}};
      end
      OP_SW: begin
        acc_c   = 1'b1;
        st_c    = 1'b1;
        size_c  = 2'd2;
        unal_c  = |a_c;
        strb_c  = 4'b1111;
        wdata_c = rt;
      end
      OP_SWL: begin
        acc_c   = LWLR_EN;
        st_c    = 1'b1;
        lr_c    = 1'b1;
        size_c  = 2'd2;
        strb_c  = 4'b1111 >> ~a_c;
        wdata_c = rt >> ish_c;
      end
      OP_SWR: begin
        acc_c   = LWLR_EN;
        st_c    = 1'b1;
        lr_c    = 1'b1;
        size_c  = 2'd2;
        strb_c  = 4'b1111 << a_c;
        wdata_c = rt << sh_c;
      end
      default: ;
    endcase
  end

  assign adelM    = valid & unal_c & ~st_c;
  assign adesM    = valid & unal_c & st_c;
  assign bad_addr = (adelM | adesM) ? addr : pc;
  assign accept   = valid & acc_c & ~unal_c & ~flush & ~rst;

  assign rsh_c = {off_q, 3'b000};
  assign msh_c = data_rdata >> rsh_c;
  assign mhf_c = data_rdata >> {off_q[1], 4'b0000};

  // Format the returned word according to the captured load op
  always_comb begin
    fmt_c = 32'h0;
    unique case (op_q)
      OP_LB:  fmt_c = {{24{msh_c[7]}}, msh_c[7:0]};
      OP_LBU: fmt_c = {24'h0, msh_c[7:0]};
      OP_LH:  fmt_c = {{16{mhf_c[15]}}, mhf_c[15:0]};
      OP_LHU: fmt_c = {16'h0, mhf_c[15:0]};
      OP_LW:  fmt_c = data_rdata;
      OP_LWL: fmt_c = (data_rdata << {~off_q, 3'b000})
                    | (rt_q & (32'h00FF_FFFF >> rsh_c));
      OP_LWR: fmt_c = msh_c
                    | (rt_q & ~(32'hFFFF_FFFF >> rsh_c));
      default: fmt_c = 32'h0;
    endcase
  end

  // Transaction FSM: next state, field capture and handshake outputs
  always_comb begin
    state_d  = state_q;
    wr_d     = wr_q;
    size_d   = size_q;
    daddr_d  = daddr_q;
    wdata_d  = wdata_q;
    wstrb_d  = wstrb_q;
    op_d     = op_q;
    off_d    = off_q;
    rt_d     = rt_q;
    rdata_d  = rdata_q;
    stall    = 1'b0;
    data_req = 1'b0;
    done     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        stall = accept;
        if (accept) begin
          state_d = S_REQ;
          wr_d    = st_c;
          size_d  = size_c;
          daddr_d = lr_c ? {addr[ADDR_W-1:2], 2'b00} : addr;
          wdata_d = wdata_c;
          wstrb_d = strb_c;
          op_d    = op;
          off_d   = a_c;
          rt_d    = rt;
        end
      end
      S_REQ: begin
        stall    = 1'b1;
        data_req = 1'b1;
        if (data_addr_ok) state_d = flush ? S_DRAIN : S_WAIT;
        else if (flush)   state_d = S_IDLE;
      end
      S_WAIT: begin
        stall = 1'b1;
        if (data_data_ok) begin
          if (flush) state_d = S_IDLE;
          else begin
            state_d = S_DONE;
            rdata_d = fmt_c;
          end
        end else if (flush) begin
          state_d = S_DRAIN;
        end
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      S_DRAIN: begin
        stall = valid;
        if (data_data_ok) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and captured request registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      wr_q    <= 1'b0;
      size_q  <= 2'd0;
      daddr_q <= '0;
      wdata_q <= 32'h0;
      wstrb_q <= 4'b0000;
      op_q    <= 6'd0;
      off_q   <= 2'd0;
      rt_q    <= 32'h0;
      rdata_q <= 32'h0;
    end else begin
      state_q <= state_d;
      wr_q    <= wr_d;
      size_q  <= size_d;
      daddr_q <= daddr_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
      op_q    <= op_d;
      off_q   <= off_d;
      rt_q    <= rt_d;
      rdata_q <= rdata_d;
    end
  end

  assign data_wr    = wr_q;
  assign data_size  = size_q;
  assign data_addr  = daddr_q;
  assign data_wdata = wdata_q;
  assign data_wstrb = wstrb_q;
  assign rdata_out  = rdata_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Randomized self-checking bench for mem_access_ctrl.
// Byte-lane reference model of MIPS load/store semantics.
module tb_mem_access_ctrl;

  localparam logic [5:0] LB  = 6'b100000, LH  = 6'b100001;
  localparam logic [5:0] LWL = 6'b100010, LW  = 6'b100011;
  localparam logic [5:0] LBU = 6'b100100, LHU = 6'b100101;
  localparam logic [5:0] LWR = 6'b100110, SB  = 6'b101000;
  localparam logic [5:0] SH  = 6'b101001, SWL = 6'b101010;
  localparam logic [5:0] SW  = 6'b101011, SWR = 6'b101110;

  logic clk = 1'b0;
  logic rst, valid, flush;
  logic [5:0] op;
  logic [31:0] pc, addr, rt;
  logic data_req, data_wr;
  logic [1:0] data_size;
  logic [31:0] data_addr, data_wdata;
  logic [3:0] data_wstrb;
  logic data_addr_ok, data_data_ok;
  logic [31:0] data_rdata;
  logic stall, done;
  logic [31:0] rdata_out;
  logic adesM, adelM;
  logic [31:0] bad_addr;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  mem_access_ctrl dut (
    .clk(clk), .rst(rst), .valid(valid), .flush(flush),
    .op(op), .pc(pc), .addr(addr), .rt(rt),
    .data_req(data_req), .data_wr(data_wr),
    .data_size(data_size), .data_addr(data_addr),
    .data_wdata(data_wdata), .data_wstrb(data_wstrb),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
    .data_rdata(data_rdata), .stall(stall), .done(done),
    .rdata_out(rdata_out), .adesM(adesM), .adelM(adelM),
    .bad_addr(bad_addr)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic logic is_store(logic [5:0] o);
    return o inside {SB, SH, SW, SWL, SWR};
  endfunction

  function automatic logic is_acc(logic [5:0] o);
    return o inside {LB, LH, LWL, LW, LBU, LHU, LWR,
                     SB, SH, SWL, SW, SWR};
  endfunction

  function automatic logic is_lr(logic [5:0] o);
    return o inside {LWL, LWR, SWL, SWR};
  endfunction

  function automatic logic misal(logic [5:0] o, logic [1:0] a);
    if (o inside {LH, LHU, SH}) return a[0];
    if (o inside {LW, SW}) return a != 2'd0;
    return 1'b0;
  endfunction

  function automatic logic [1:0] ref_size(logic [5:0] o);
    if (o inside {LB, LBU, SB}) return 2'd0;
    if (o inside {LH, LHU, SH}) return 2'd1;
    return 2'd2;
  endfunction

  // Store lanes: which memory bytes are written and with what
  task automatic ref_store(input logic [5:0] o, input logic [1:0] a,
                           input logic [31:0] r,
                           output logic [3:0] s,
                           output logic [31:0] w);
    logic [7:0] rb [4];
    logic [7:0] lane [4];
    int ai;
    ai = int'(a);
    for (int i = 0; i < 4; i++) rb[i] = r[8*i +: 8];
    for (int i = 0; i < 4; i++) lane[i] = 8'h00;
    s = 4'b0000;
    case (o)
      SB: begin
        for (int i = 0; i < 4; i++) lane[i] = rb[0];
        s[ai] = 1'b1;
      end
      SH: begin
        for (int i = 0; i < 4; i++) lane[i] = rb[i % 2];
        s[2*(ai/2)] = 1'b1;
        s[2*(ai/2)+1] = 1'b1;
      end
      SW: begin
        for (int i = 0; i < 4; i++) lane[i] = rb[i];
        s = 4'b1111;
      end
      SWL: for (int i = 0; i <= ai; i++) begin
        lane[i] = rb[3-ai+i];
        s[i] = 1'b1;
      end
      SWR: for (int i = ai; i < 4; i++) begin
        lane[i] = rb[i-ai];
        s[i] = 1'b1;
      end
      default: ;
    endcase
    w = {lane[3], lane[2], lane[1], lane[0]};
  endtask

  function automatic logic [31:0] ref_load(logic [5:0] o,
      logic [1:0] a, logic [31:0] r, logic [31:0] m);
    logic [7:0] mb [4];
    logic [7:0] ob [4];
    logic [7:0] b;
    logic [15:0] h;
    int ai;
    ai = int'(a);
    for (int i = 0; i < 4; i++) begin
      mb[i] = m[8*i +: 8];
      ob[i] = r[8*i +: 8];
    end
    b = mb[ai];
    h = {mb[2*(ai/2)+1], mb[2*(ai/2)]};
    case (o)
      LB:  return {{24{b[7]}}, b};
      LBU: return {24'h0, b};
      LH:  return {{16{h[15]}}, h};
      LHU: return {16'h0, h};
      LW:  return m;
      LWL: for (int i = 0; i <= ai; i++) ob[3-ai+i] = mb[i];
      LWR: for (int i = ai; i < 4; i++) ob[i-ai] = mb[i];
      default: return 32'h0;
    endcase
    return {ob[3], ob[2], ob[1], ob[0]};
  endfunction

  // One accepted access with given handshake delays, all phases checked
  task automatic run_txn(input logic [5:0] o, input logic [31:0] ad,
                         input logic [31:0] r, input logic [31:0] m,
                         input int aok, input int dok,
                         output logic [31:0] oa,
                         output logic [3:0] os,
                         output logic [31:0] ow,
                         output logic [31:0] orr);
    logic [3:0] es;
    logic [31:0] ew, ea, er;
    logic [70:0] exp_f, got_f;
    ref_store(o, ad[1:0], r, es, ew);
    ea = is_lr(o) ? {ad[31:2], 2'b00} : ad;
    er = is_store(o) ? 32'h0 : ref_load(o, ad[1:0], r, m);
    exp_f = {1'b1, is_store(o), ref_size(o), ea, es, ew};
    valid = 1'b1; flush = 1'b0;
    op = o; addr = ad; rt = r; pc = $urandom;
    @(negedge clk);
    total++;
    if ({stall, adelM, adesM} !== 3'b100) begin
      bad++;
      $display("FAIL accept op=%b: stall/adel/ades=%b want 100",
               o, {stall, adelM, adesM});
    end
    cyc();
    for (int i = 0; i <= aok; i++) begin
      data_addr_ok = (i == aok);
      addr = $urandom; rt = $urandom;
      @(negedge clk);
      got_f = {data_req, data_wr, data_size, data_addr,
               data_wstrb, data_wdata};
      total++;
      if (got_f !== exp_f || stall !== 1'b1) begin
        bad++;
        $display("FAIL req op=%b cyc=%0d: fields=%h stall=%b want %h 1",
                 o, i, got_f, stall, exp_f);
      end
      oa = data_addr; os = data_wstrb; ow = data_wdata;
      cyc();
    end
    data_addr_ok = 1'b0;
    for (int i = 0; i <= dok; i++) begin
      data_data_ok = (i == dok);
      data_rdata = (i == dok) ? m : $urandom;
      @(negedge clk);
      total++;
      if ({data_req, stall, done} !== 3'b010) begin
        bad++;
        $display("FAIL wait op=%b cyc=%0d: req/stall/done=%b want 010",
                 o, i, {data_req, stall, done});
      end
      cyc();
    end
    data_data_ok = 1'b0; valid = 1'b0;
    @(negedge clk);
    orr = rdata_out;
    total++;
    if (done !== 1'b1 || stall !== 1'b0 || rdata_out !== er) begin
      bad++;
      $display("FAIL done op=%b: done=%b stall=%b rdata=%h want 1 0 %h",
               o, done, stall, rdata_out, er);
    end
    cyc();
    @(negedge clk);
    total++;
    if (done !== 1'b0 || data_req !== 1'b0) begin
      bad++;
      $display("FAIL post op=%b: done=%b req=%b want 0 0",
               o, done, data_req);
    end
    cyc();
  endtask

  task automatic test_reset();
    rst = 1'b1; valid = 1'b0; flush = 1'b0;
    op = 6'd0; pc = 32'h0; addr = 32'h0; rt = 32'h0;
    data_addr_ok = 1'b0; data_data_ok = 1'b0; data_rdata = 32'h0;
    cyc(); cyc();
    @(negedge clk);
    total++;
    if ({data_req, done, stall} !== 3'b000 || rdata_out !== 32'h0) begin
      bad++;
      $display("FAIL reset: req/done/stall=%b rdata=%h want 000 0",
               {data_req, done, stall}, rdata_out);
    end
    cyc();
    rst = 1'b0;
    cyc();
  endtask

  task automatic test_lw_latency();
    logic [31:0] oa, ow, orr;
    logic [3:0] os;
    run_txn(LW, 32'h1000, 32'h0, 32'h8899AABB, 0, 0, oa, os, ow, orr);
    total++;
    if (orr !== 32'h8899AABB || oa !== 32'h1000) begin
      bad++;
      $display("FAIL lw_basic: rdata=%h addr=%h want 8899aabb 1000",
               orr, oa);
    end
  endtask

  task automatic test_misaligned();
    valid = 1'b1; op = LH; addr = 32'h1001; pc = 32'h400;
    @(negedge clk);
    total++;
    if ({adelM, adesM, stall} !== 3'b100 || bad_addr !== 32'h1001) begin
      bad++;
      $display("FAIL lh_adel: adel/ades/stall=%b bad=%h want 100 1001",
               {adelM, adesM, stall}, bad_addr);
    end
    cyc();
    @(negedge clk);
    total++;
    if (data_req !== 1'b0) begin
      bad++;
      $display("FAIL lh_noreq: data_req=%b want 0", data_req);
    end
    cyc();
    op = SW; addr = 32'h1002;
    @(negedge clk);
    total++;
    if ({adelM, adesM, stall} !== 3'b010 || bad_addr !== 32'h1002) begin
      bad++;
      $display("FAIL sw_ades: adel/ades/stall=%b bad=%h want 010 1002",
               {adelM, adesM, stall}, bad_addr);
    end
    cyc();
    valid = 1'b0; op = LW; addr = 32'h1003; pc = 32'h404;
    @(negedge clk);
    total++;
    if ({adelM, adesM} !== 2'b00 || bad_addr !== 32'h404) begin
      bad++;
      $display("FAIL novalid: adel/ades=%b bad=%h want 00 404",
               {adelM, adesM}, bad_addr);
    end
    cyc();
  endtask

  task automatic test_byte_ops();
    logic [31:0] oa, ow, orr;
    logic [3:0] os;
    run_txn(SB, 32'h2003, 32'h12345678, 32'h0, 1, 1, oa, os, ow, orr);
    total++;
    if (os !== 4'b1000 || ow !== 32'h78787878 || orr !== 32'h0) begin
      bad++;
      $display("FAIL sb: wstrb=%b wdata=%h rdata=%h want 1000 78787878 0",
               os, ow, orr);
    end
    run_txn(LB, 32'h2003, 32'h0, 32'h80123456, 0, 2, oa, os, ow, orr);
    total++;
    if (orr !== 32'hFFFFFF80 || os !== 4'b0000) begin
      bad++;
      $display("FAIL lb: rdata=%h wstrb=%b want ffffff80 0000", orr, os);
    end
  endtask

  task automatic test_lwl_swr();
    logic [31:0] oa, ow, orr;
    logic [3:0] os;
    run_txn(LWL, 32'h3001, 32'h11223344, 32'hAABBCCDD, 0, 0,
            oa, os, ow, orr);
    total++;
    if (oa !== 32'h3000 || orr !== 32'hCCDD3344) begin
      bad++;
      $display("FAIL lwl: addr=%h rdata=%h want 3000 ccdd3344", oa, orr);
    end
    run_txn(SWR, 32'h3002, 32'h11223344, 32'h0, 0, 0, oa, os, ow, orr);
    total++;
    if (os !== 4'b1100 || ow !== 32'h33440000 || oa !== 32'h3000) begin
      bad++;
      $display("FAIL swr: wstrb=%b wdata=%h addr=%h want 1100 33440000 3000",
               os, ow, oa);
    end
  endtask

  task automatic test_flush();
    logic [31:0] oa, ow, orr;
    logic [3:0] os;
    int dn;
    valid = 1'b1; flush = 1'b0; op = LW; addr = 32'h5000; rt = 32'h0;
    cyc();
    data_addr_ok = 1'b1;
    cyc();
    data_addr_ok = 1'b0; flush = 1'b1; valid = 1'b0;
    cyc();
    flush = 1'b0;
    dn = 0;
    for (int i = 0; i < 5; i++) begin
      data_data_ok = (i == 2);
      data_rdata = 32'hDEADBEEF;
      @(negedge clk);
      if (done !== 1'b0) dn++;
      cyc();
    end
    data_data_ok = 1'b0;
    total++;
    if (dn != 0) begin
      bad++;
      $display("FAIL flush_wait: done pulses=%0d want 0", dn);
    end
    valid = 1'b1; op = LW; addr = 32'h5004;
    cyc();
    flush = 1'b1; valid = 1'b0;
    @(negedge clk);
    cyc();
    flush = 1'b0; data_data_ok = 1'b1;
    @(negedge clk);
    total++;
    if (data_req !== 1'b0 || stall !== 1'b0) begin
      bad++;
      $display("FAIL flush_req: req=%b stall=%b want 0 0", data_req, stall);
    end
    cyc();
    data_data_ok = 1'b0;
    @(negedge clk);
    total++;
    if (done !== 1'b0) begin
      bad++;
      $display("FAIL stray_ok: done=%b want 0", done);
    end
    cyc();
    run_txn(LW, 32'h5008, 32'h0, 32'h01020304, 0, 0, oa, os, ow, orr);
    total++;
    if (orr !== 32'h01020304) begin
      bad++;
      $display("FAIL after_flush: rdata=%h want 01020304", orr);
    end
  endtask

  task automatic test_hold_and_reset();
    logic [31:0] oa, ow, orr;
    logic [3:0] os;
    run_txn(SW, 32'h6004, 32'hCAFEF00D, 32'h0, 5, 0, oa, os, ow, orr);
    run_txn(LHU, 32'h6002, 32'h0, 32'hBEEF1234, 0, 0, oa, os, ow, orr);
    valid = 1'b1; op = LW; addr = 32'h7000;
    cyc();
    data_addr_ok = 1'b1;
    cyc();
    data_addr_ok = 1'b0; valid = 1'b0; rst = 1'b1;
    cyc();
    @(negedge clk);
    total++;
    if ({data_req, done, stall} !== 3'b000 || rdata_out !== 32'h0) begin
      bad++;
      $display("FAIL rst_wait: req/done/stall=%b rdata=%h want 000 0",
               {data_req, done, stall}, rdata_out);
    end
    cyc();
    rst = 1'b0;
    data_data_ok = 1'b1;
    cyc();
    data_data_ok = 1'b0;
    @(negedge clk);
    total++;
    if (done !== 1'b0) begin
      bad++;
      $display("FAIL rst_stray: done=%b want 0", done);
    end
    cyc();
  endtask

  task automatic test_random();
    logic [5:0] ops [14];
    logic [5:0] o;
    logic [31:0] ad, oa, ow, orr;
    logic [3:0] os;
    ops = '{LB, LH, LWL, LW, LBU, LHU, LWR,
            SB, SH, SWL, SW, SWR, 6'b000000, 6'b101100};
    for (int n = 0; n < 60; n++) begin
      o = ops[$urandom_range(13)];
      ad = $urandom;
      if (is_acc(o) && !misal(o, ad[1:0])) begin
        run_txn(o, ad, $urandom, $urandom, $urandom_range(3),
                $urandom_range(3), oa, os, ow, orr);
      end else begin
        valid = 1'b1; op = o; addr = ad; pc = $urandom;
        @(negedge clk);
        total++;
        if (stall !== 1'b0 ||
            adelM !== (misal(o, ad[1:0]) && !is_store(o)) ||
            adesM !== (misal(o, ad[1:0]) && is_store(o)) ||
            bad_addr !== (misal(o, ad[1:0]) ? ad : pc)) begin
          bad++;
          $display("FAIL rnd_noacc op=%b a=%h: stall=%b adel=%b ades=%b bad=%h",
                   o, ad, stall, adelM, adesM, bad_addr);
        end
        cyc();
        valid = 1'b0;
        @(negedge clk);
        total++;
        if (data_req !== 1'b0) begin
          bad++;
          $display("FAIL rnd_noreq op=%b: data_req=%b want 0", o, data_req);
        end
        cyc();
      end
    end
  endtask

  initial begin
    #1;
    test_reset();
    test_lw_latency();
    test_misaligned();
    test_byte_ops();
    test_lwl_swr();
    test_flush();
    test_hold_and_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
